// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_pkg
// Description : Shared definitions for the bit-serial subtractor.
//               - FSM state encodings (2-bit): IDLE, SHIFT, DONE
//               - clog2_f: ceiling log2 helper used to size the bit counter
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

    // FSM state encodings
    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_shift = 2'd1;
    localparam logic [1:0] c_done  = 2'd2;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2_f(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >>> 1;
        end
        return res;
    endfunction

endpackage : serial_subtractor_pkg
`default_nettype wire

// File: rtl/serial_subtractor_half_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : half_subtractor
// Description : One-bit half subtractor, x - y.
// Ports       : x      - minuend bit
//               y      - subtrahend bit
//               diff   - difference bit  (x ^ y)
//               borrow - borrow-out      (~x & y)
// Revision    : 1.0 - initial release
// ============================================================================
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic diff,
    output logic borrow
);

    assign diff   = x ^ y;
    assign borrow = ~x & y;

endmodule : half_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial unsigned subtractor, diff = a - b, LSB first, one
//               bit per clock with a registered borrow. Operands are captured
//               on an accepted start; the result is published with a one-cycle
//               done pulse WIDTH+1 edges after acceptance and held until the
//               next result.
// Parameters  : WIDTH  - operand/result width, 2..32 (default 8)
// Ports       : clk    - clock, rising edge
//               rst    - asynchronous active-high reset
//               start  - request pulse, sampled only in IDLE
//               a, b   - minuend / subtrahend, captured on accepted start
//               busy   - high while bits are being shifted (SHIFT state)
//               done   - one-cycle pulse when diff/borrow are updated
//               diff   - a - b modulo 2^WIDTH
//               borrow - 1 when a < b (unsigned)
//               ovf    - signed overflow (only with SERIAL_SUB_OVF_EN)
// Options     : SERIAL_SUB_OVF_EN - adds the ovf output and its logic
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Counter holds 0..WIDTH, so one bit beyond clog2 avoids wrap-around.
    localparam int              CNT_W  = clog2_f(WIDTH) + 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic             r_bin;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    logic             w_d1;
    logic             w_b1;
    logic             w_d;
    logic             w_b2;
    logic             w_bout;

    // Full-subtract cell: (a - b) first, then subtract the incoming borrow.
    half_subtractor u_hs_ab (
        .x      (r_a_sh[0]),
        .y      (r_b_sh[0]),
        .diff   (w_d1),
        .borrow (w_b1)
    );

    half_subtractor u_hs_bin (
        .x      (w_d1),
        .y      (r_bin),
        .diff   (w_d),
        .borrow (w_b2)
    );

    // At most one of the two stages can borrow, so OR merges them.
    assign w_bout = w_b1 | w_b2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_idle;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res    <= '0;
            r_bin    <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_bin   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= c_shift;
                    end
                end
                c_shift: begin
                    // Result bits enter at the MSB and march toward bit 0,
                    // so after WIDTH shifts the first bit sits at the LSB.
                    r_res  <= {w_d, r_res[WIDTH-1:1]};
                    r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_bin  <= w_bout;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_state <= c_done;
                    end
                end
                c_done: begin
                    r_diff   <= r_res;
                    r_borrow <= r_bin;
                    r_done   <= 1'b1;
                    r_state  <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are shifted out of a_sh/b_sh, so keep copies.
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (r_state == c_idle && start) begin
                r_a_msb <= a[WIDTH-1];
                r_b_msb <= b[WIDTH-1];
            end
            if (r_state == c_done) begin
                // Overflow only when signs differ and the result sign
                // disagrees with the minuend sign.
                r_ovf <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ r_res[WIDTH-1]);
            end
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy   = (r_state == c_shift);
    assign done   = r_done;
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule : serial_subtractor
`default_nettype wire
